// File: rtl/rst_seq_if.sv
// Handshake bundle between the reset sequencer and its requesters and reset domains.
interface rst_seq_if #(
  parameter int N_REQ = 3,
  parameter int N_DOM = 4
);
  logic [N_REQ-1:0] soft_rst_req;
  logic [N_REQ-1:0] soft_rst_ack;
  logic [N_DOM-1:0] dom_rst_n;
  logic [N_DOM-1:0] dom_rdy;
  logic             seq_busy;
  logic [N_REQ-1:0] rst_cause;
  logic             cause_clr;
  logic [N_DOM-1:0] err_tmo;

  modport slave (
    input  soft_rst_req, dom_rdy, cause_clr,
    output soft_rst_ack, dom_rst_n, seq_busy, rst_cause, err_tmo
  );

  modport master (
    output soft_rst_req, dom_rdy, cause_clr,
    input  soft_rst_ack, dom_rst_n, seq_busy, rst_cause, err_tmo
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges soft-reset requests, holds all domains, then releases them in order.
// Optional RST_RDY_TIMEOUT_EN: each release step also waits for dom_rdy with a per-domain timeout.
module rst_seq_ctrl #(
  parameter int N_REQ    = 3,
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 4,
  parameter int TMO_CYC  = 64
) (
  input  logic         clk,
  input  logic         rst,
  rst_seq_if.slave     bus
);

  localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_C  = (MAX_HG > TMO_CYC) ? MAX_HG : TMO_CYC;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] svc_q, svc_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] cause_q, cause_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] req_prev_q;
  logic [N_DOM-1:0] err_q, err_d;
  logic [N_DOM-1:0] dom_q, dom_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] rise;
  logic             step_end;

`ifndef RST_RDY_TIMEOUT_EN
  logic unused_rdy;
  assign unused_rdy = ^bus.dom_rdy;
`endif

  always_comb begin
    // Per-bit rising edge so a stuck requester cannot loop the sequencer.
    rise     = bus.soft_rst_req & ~req_prev_q;
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    svc_d    = svc_q;
    pend_d   = pend_q;
    err_d    = err_q;
    cause_d  = (bus.cause_clr ? '0 : cause_q) | rise;
    step_end = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|rise) begin
          state_d = ASSERT;
          svc_d   = rise;
        end
      end
      ASSERT: begin
        if (|rise) begin
          svc_d = svc_q | rise;
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        pend_d = pend_q | rise;
`ifdef RST_RDY_TIMEOUT_EN
        step_end = (cnt_q >= CNT_W'(GAP_CYC - 1)) &&
                   (bus.dom_rdy[idx_q] || (cnt_q >= CNT_W'(TMO_CYC - 1)));
        if ((cnt_q >= CNT_W'(TMO_CYC - 1)) && !bus.dom_rdy[idx_q])
          err_d[idx_q] = 1'b1;
`else
        step_end = (cnt_q == CNT_W'(GAP_CYC - 1));
`endif
        if (step_end) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(N_DOM - 1))
            state_d = DONE;
          else
            idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        if (|(pend_q | rise)) begin
          svc_d   = pend_q | rise;
          pend_d  = '0;
          state_d = ASSERT;
        end else begin
          svc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = ASSERT;
    endcase

    // Outputs are registered from the next state so they line up with it.
    dom_d = '1;
    if (state_d == ASSERT) begin
      dom_d = '0;
    end else if (state_d == RELEASE) begin
      for (int i = 0; i < N_DOM; i++)
        dom_d[i] = (int'(idx_d) >= i);
    end
    ack_d  = (state_d == DONE) ? svc_q : '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    req_prev_q <= bus.soft_rst_req;
    if (rst) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      svc_q   <= '0;
      pend_q  <= '0;
      cause_q <= '0;
      err_q   <= '0;
      dom_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      svc_q   <= svc_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      err_q   <= err_d;
      dom_q   <= dom_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dom_rst_n    = dom_q;
  assign bus.soft_rst_ack = ack_q;
  assign bus.seq_busy     = busy_q;
  assign bus.rst_cause    = cause_q;
  assign bus.err_tmo      = err_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: POR, soft reset, merge/pending, mid-sequence reset, sticky cause.
module tb_rst_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] ack_or = '0;

  rst_seq_if #(.N_REQ(3), .N_DOM(4)) bus ();

  rst_seq_ctrl #(
    .N_REQ(3), .N_DOM(4), .HOLD_CYC(16), .GAP_CYC(4), .TMO_CYC(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ack_or = ack_or | bus.soft_rst_ack;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int r0;
    bus.soft_rst_req = '0;
    bus.dom_rdy      = '1;
    bus.cause_clr    = 1'b0;

    // Power-on: five cycles of reset, then cycle 0 begins.
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_dom",   32'(bus.dom_rst_n), 32'h0);
    chk("rst_busy",  32'(bus.seq_busy), 32'h1);
    chk("rst_cause", 32'(bus.rst_cause), 32'h0);
    chk("rst_ack",   32'(bus.soft_rst_ack), 32'h0);
    chk("rst_err",   32'(bus.err_tmo), 32'h0);
    rst = 1'b0;
    cyc = 0;
    ack_or = '0;
    goto(15); chk("por_dom15", 32'(bus.dom_rst_n), 32'h0);
    goto(16); chk("por_dom16", 32'(bus.dom_rst_n), 32'h1);
    goto(20); chk("por_dom20", 32'(bus.dom_rst_n), 32'h3);
    goto(24); chk("por_dom24", 32'(bus.dom_rst_n), 32'h7);
    goto(28); chk("por_dom28", 32'(bus.dom_rst_n), 32'hF);
    goto(32); chk("por_busy32", 32'(bus.seq_busy), 32'h1);
    goto(33); chk("por_busy33", 32'(bus.seq_busy), 32'h0);
    chk("por_noack",  32'(ack_or), 32'h0);
    chk("por_cause",  32'(bus.rst_cause), 32'h0);

    // Single soft reset from requester 1 at t=40.
    goto(40); bus.soft_rst_req = 3'b010;
    tick();   bus.soft_rst_req = 3'b000;
    chk("soft_dom_t1",   32'(bus.dom_rst_n), 32'h0);
    chk("soft_cause_t1", 32'(bus.rst_cause), 32'h2);
    goto(68); chk("soft_dom_t28", 32'(bus.dom_rst_n), 32'h7);
    goto(69); chk("soft_dom_t29", 32'(bus.dom_rst_n), 32'hF);
    goto(72); chk("soft_ack_t32", 32'(bus.soft_rst_ack), 32'h0);
    goto(73); chk("soft_ack_t33", 32'(bus.soft_rst_ack), 32'h2);
    goto(74); chk("soft_ack_t34", 32'(bus.soft_rst_ack), 32'h0);
    chk("soft_idle", 32'(bus.seq_busy), 32'h0);

    // Clear and a new request in the same cycle: the request wins its bit.
    goto(80); bus.cause_clr = 1'b1; bus.soft_rst_req = 3'b001;
    tick();   bus.cause_clr = 1'b0; bus.soft_rst_req = 3'b000;
    chk("cause_clr_req", 32'(bus.rst_cause), 32'h1);
    goto(113); chk("cause_seq_ack", 32'(bus.soft_rst_ack), 32'h1);
    goto(120); bus.cause_clr = 1'b1;
    tick();    bus.cause_clr = 1'b0;
    chk("cause_clr_only", 32'(bus.rst_cause), 32'h0);

    // Merge in ASSERT (restarts hold) and pending from RELEASE.
    goto(130); bus.soft_rst_req = 3'b001;
    tick();    bus.soft_rst_req = 3'b000;
    goto(135); bus.soft_rst_req = 3'b100;
    tick();    bus.soft_rst_req = 3'b000;
    goto(147); chk("merge_hold_restart", 32'(bus.dom_rst_n), 32'h0);
    goto(151); chk("merge_dom151", 32'(bus.dom_rst_n), 32'h0);
    goto(152); chk("merge_dom152", 32'(bus.dom_rst_n), 32'h1);
    goto(155); bus.soft_rst_req = 3'b010;
    tick();    bus.soft_rst_req = 3'b000;
    chk("merge_undisturbed", 32'(bus.dom_rst_n), 32'h3);
    goto(168); chk("merge_ack1", 32'(bus.soft_rst_ack), 32'h5);
    goto(169); chk("merge_reassert", 32'(bus.dom_rst_n), 32'h0);
    chk("merge_ack1_end", 32'(bus.soft_rst_ack), 32'h0);
    goto(200); chk("merge_ack2_pre", 32'(bus.soft_rst_ack), 32'h0);
    goto(201); chk("merge_ack2", 32'(bus.soft_rst_ack), 32'h2);
    goto(202); chk("merge_idle", 32'(bus.seq_busy), 32'h0);
    chk("merge_cause", 32'(bus.rst_cause), 32'h7);

    // Reset during RELEASE idx=2 with a pending request latched.
    goto(210); bus.soft_rst_req = 3'b001;
    tick();    bus.soft_rst_req = 3'b000;
    goto(232); bus.soft_rst_req = 3'b010;
    tick();    bus.soft_rst_req = 3'b000;
    goto(235); chk("mid_idx2", 32'(bus.dom_rst_n), 32'h7);
    goto(236); rst = 1'b1;
    tick();
    chk("mid_dom", 32'(bus.dom_rst_n), 32'h0);
    chk("mid_busy", 32'(bus.seq_busy), 32'h1);
    chk("mid_cause", 32'(bus.rst_cause), 32'h0);
    rst = 1'b0;
    r0 = cyc;
    ack_or = '0;
    goto(r0 + 16); chk("mid_por16", 32'(bus.dom_rst_n), 32'h1);
    goto(r0 + 28); chk("mid_por28", 32'(bus.dom_rst_n), 32'hF);
    goto(r0 + 33); chk("mid_idle", 32'(bus.seq_busy), 32'h0);
    goto(r0 + 36); chk("mid_noack", 32'(ack_or), 32'h0);
    chk("mid_cause_end", 32'(bus.rst_cause), 32'h0);

`ifdef RST_RDY_TIMEOUT_EN
    // Domain 1 never reports ready: its step times out after 64 cycles.
    goto(280); bus.dom_rdy = 4'b1101;
    goto(290); bus.soft_rst_req = 3'b001;
    tick();    bus.soft_rst_req = 3'b000;
    goto(290 + 65); chk("tmo_step1", 32'(bus.dom_rst_n), 32'h3);
    goto(290 + 85); chk("tmo_step2", 32'(bus.dom_rst_n), 32'h7);
    goto(290 + 93); chk("tmo_ack", 32'(bus.soft_rst_ack), 32'h1);
    chk("tmo_err", 32'(bus.err_tmo), 32'h2);
    chk("tmo_dom", 32'(bus.dom_rst_n), 32'hF);
`else
    goto(280); bus.dom_rdy = 4'b0000;
    goto(290); bus.soft_rst_req = 3'b001;
    tick();    bus.soft_rst_req = 3'b000;
    goto(290 + 25); chk("nordy_step2", 32'(bus.dom_rst_n), 32'h7);
    goto(290 + 33); chk("nordy_ack", 32'(bus.soft_rst_ack), 32'h1);
    chk("nordy_err", 32'(bus.err_tmo), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
